// File: rtl/commit_trace_checker_pkg.sv
// trace_pkg: shared definitions for the commit-trace checker.
//   - Trace record width and field bit offsets. A record packs
//     {pc[15:0], regwrite, wreg[2:0], wdata[15:0], memread, memwrite,
//      addr[15:0], mdata[15:0], halt} into bits [70:0]. Bits [86:71] are
//     reserved and never compared.
//   - Error codes reported on err_code.
//   - Checker FSM state encodings.
//   - trace_compare(): ordered field comparison, first hit wins.
package trace_pkg;

  localparam int TRACE_REC_W    = 87;
  localparam int TRACE_FIELDS_W = 71;

  localparam int HALT_BIT     = 0;
  localparam int MDATA_LSB    = 1;
  localparam int ADDR_LSB     = 17;
  localparam int MEMWRITE_BIT = 33;
  localparam int MEMREAD_BIT  = 34;
  localparam int WDATA_LSB    = 35;
  localparam int WREG_LSB     = 51;
  localparam int REGWRITE_BIT = 54;
  localparam int PC_LSB       = 55;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_PC        = 3'd1;
  localparam logic [2:0] ERR_REG       = 3'd2;
  localparam logic [2:0] ERR_MEM       = 3'd3;
  localparam logic [2:0] ERR_HALT      = 3'd4;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd5;
  localparam logic [2:0] ERR_EXTRA     = 3'd6;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  // Field layout of bits [70:0], MSB first; must agree with the offsets above.
  typedef struct packed {
    logic [15:0] pc;
    logic        regwrite;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic        memread;
    logic        memwrite;
    logic [15:0] addr;
    logic [15:0] mdata;
    logic        halt;
  } trace_rec_t;

  // Fields that are don't-care for the expected record's operation
  // (wreg/wdata without regwrite, addr without a memory access, mdata
  // without memwrite) are masked out.
  function automatic logic [2:0] trace_compare(trace_rec_t e, trace_rec_t a);
    if (e.pc != a.pc) return ERR_PC;
    if ((e.regwrite != a.regwrite) ||
        (e.regwrite && ((e.wreg != a.wreg) || (e.wdata != a.wdata))))
      return ERR_REG;
    if ((e.memread != a.memread) || (e.memwrite != a.memwrite) ||
        ((e.memread || e.memwrite) && (e.addr != a.addr)) ||
        (e.memwrite && (e.mdata != a.mdata)))
      return ERR_MEM;
    if (e.halt != a.halt) return ERR_HALT;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/commit_trace_checker_if.sv
// commit_trace_checker_if: golden-record input and live commit port.
//   exp_valid/exp_ready/exp_rec : golden record stream. A record transfers on
//     a rising clk edge where exp_valid && exp_ready; the source holds
//     exp_valid and exp_rec stable until that edge, and exp_ready may be
//     low at any time without regard to exp_valid.
//   cm_valid/cm_rec : one retired instruction per cycle with cm_valid high;
//     there is no backpressure on this side.
// master: record loader / core side. slave: the checker.
interface commit_trace_checker_if;
  import trace_pkg::*;

  logic                   exp_valid;
  logic                   exp_ready;
  logic [TRACE_REC_W-1:0] exp_rec;
  logic                   cm_valid;
  logic [TRACE_REC_W-1:0] cm_rec;

  modport master (output exp_valid, exp_rec, cm_valid, cm_rec, input exp_ready);
  modport slave  (input exp_valid, exp_rec, cm_valid, cm_rec, output exp_ready);
endinterface

// File: rtl/commit_trace_checker_fifo.sv
// trace_fifo: DEPTH x W synchronous FIFO with show-ahead head.
//   clk, rst (async, active-low) ; push/pushData ; pop ; headData (valid when
//   !empty) ; full ; empty. Push is dropped when full and pop when empty, so
//   a same-cycle push+pop while full only pops. Reset empties the FIFO.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 87
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] headData,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]  wrPtr;
  logic [AW:0]  rdPtr;
  logic         doPush;
  logic         doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign headData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end
endmodule

// File: rtl/commit_trace_checker.sv
// commit_trace_checker: compares live commit records against a buffered
// stream of golden records and latches the first divergence.
//   clk, rst (async, active-low)
//   tr         : commit_trace_checker_if.slave (golden stream + commit port)
//   done       : halt record matched (sticky)
//   fail       : mismatch / protocol error (sticky)
//   inst_count : records matched so far (wraps at 32 bits)
//   err_inum   : inst_count at the first failure
//   err_code   : first failure cause (trace_pkg ERR_*)
//   dbgState   : current FSM state
// Optional build macro COMMIT_TRACE_TIMEOUT_EN adds an idle watchdog that
// fails after TIMEOUT_CYCLES consecutive RUN cycles without a commit.
module commit_trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  commit_trace_checker_if.slave         tr,
  output logic                          done,
  output logic                          fail,
  output logic [31:0]                   inst_count,
  output logic [31:0]                   err_inum,
  output logic [2:0]                    err_code,
  output state_t                        dbgState
);
  state_t                 state;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [TRACE_REC_W-1:0] headRec;
  logic                   pushEn;
  logic                   popEn;
  trace_rec_t             expFields;
  trace_rec_t             cmFields;
  logic [2:0]             cmpErr;
  logic                   unusedReserved;

  // Gating with rst keeps exp_ready low while reset is held.
  assign tr.exp_ready = rst && (state == ST_RUN) && !fifoFull;
  assign pushEn       = tr.exp_valid && tr.exp_ready;
  assign popEn        = (state == ST_RUN) && tr.cm_valid && !fifoEmpty;

  trace_fifo #(.DEPTH(DEPTH), .W(TRACE_REC_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushEn),
    .pushData (tr.exp_rec),
    .pop      (popEn),
    .headData (headRec),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign expFields      = headRec[TRACE_FIELDS_W-1:0];
  assign cmFields       = tr.cm_rec[TRACE_FIELDS_W-1:0];
  assign unusedReserved = ^{headRec[TRACE_REC_W-1:TRACE_FIELDS_W],
                            tr.cm_rec[TRACE_REC_W-1:TRACE_FIELDS_W]};
  // An empty FIFO is checked first; a record pushed this same cycle is not
  // visible at the head yet, so it cannot rescue the commit.
  assign cmpErr = fifoEmpty ? ERR_UNDERFLOW : trace_compare(expFields, cmFields);
  assign dbgState = state;

`ifdef COMMIT_TRACE_TIMEOUT_EN
  localparam logic [31:0] IdleLimit = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] idleCnt;
`else
  logic [31:0] unusedTimeout;
  assign unusedTimeout = 32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      done       <= 1'b0;
      fail       <= 1'b0;
      inst_count <= '0;
      err_inum   <= '0;
      err_code   <= ERR_NONE;
`ifdef COMMIT_TRACE_TIMEOUT_EN
      idleCnt    <= '0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          if (tr.cm_valid) begin
`ifdef COMMIT_TRACE_TIMEOUT_EN
            idleCnt <= '0;
`endif
            if (cmpErr == ERR_NONE) begin
              inst_count <= inst_count + 32'd1;
              if (cmFields.halt) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end else begin
              state    <= ST_FAIL;
              fail     <= 1'b1;
              err_inum <= inst_count;
              err_code <= cmpErr;
            end
          end
`ifdef COMMIT_TRACE_TIMEOUT_EN
          else if (idleCnt == IdleLimit) begin
            state    <= ST_FAIL;
            fail     <= 1'b1;
            err_inum <= inst_count;
            err_code <= ERR_TIMEOUT;
          end else begin
            idleCnt <= idleCnt + 32'd1;
          end
`endif
        end
        ST_DONE: begin
          // Anything retiring after the halt is an extra commit; done stays set.
          if (tr.cm_valid) begin
            state    <= ST_FAIL;
            fail     <= 1'b1;
            err_inum <= inst_count;
            err_code <= ERR_EXTRA;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_commit_trace_checker.sv
module tb_commit_trace_checker;
  import trace_pkg::*;

  localparam int W = TRACE_REC_W;

  logic        clk;
  logic        rst;
  logic        done;
  logic        fail;
  logic [31:0] inst_count;
  logic [31:0] err_inum;
  logic [2:0]  err_code;
  state_t      dbg_state;

  int n_checks;
  int n_pass;

  // Expected status after each commit: {done, fail, inst_count, err_inum, err_code}.
  logic [68:0] exp_q[$];

  commit_trace_checker_if tr ();

  commit_trace_checker #(.DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .tr         (tr.slave),
    .done       (done),
    .fail       (fail),
    .inst_count (inst_count),
    .err_inum   (err_inum),
    .err_code   (err_code),
    .dbgState   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] mk_rec(input logic [15:0] pc, input logic rw,
      input logic [2:0] wreg, input logic [15:0] wdata, input logic mr, input logic mw,
      input logic [15:0] addr, input logic [15:0] mdata, input logic halt);
    logic [W-1:0] r;
    r = '0;
    r[PC_LSB +: 16]   = pc;
    r[REGWRITE_BIT]   = rw;
    r[WREG_LSB +: 3]  = wreg;
    r[WDATA_LSB +: 16] = wdata;
    r[MEMREAD_BIT]    = mr;
    r[MEMWRITE_BIT]   = mw;
    r[ADDR_LSB +: 16] = addr;
    r[MDATA_LSB +: 16] = mdata;
    r[HALT_BIT]       = halt;
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    tr.exp_valid = 1'b0;
    tr.cm_valid  = 1'b0;
    tr.exp_rec   = '0;
    tr.cm_rec    = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load(input logic [W-1:0] rec);
    bit accepted;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      tr.exp_valid = 1'b1;
      tr.exp_rec   = rec;
      accepted     = tr.exp_ready;
      @(posedge clk);
      #1;
      tr.exp_valid = 1'b0;
    end
    if (!accepted) check("load.accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop_and_check(input string tag);
    logic [68:0] e;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".done"},  {31'd0, done},     {31'd0, e[68]});
    check({tag, ".fail"},  {31'd0, fail},     {31'd0, e[67]});
    check({tag, ".count"}, inst_count,        e[66:35]);
    check({tag, ".inum"},  err_inum,          e[34:3]);
    check({tag, ".code"},  {29'd0, err_code}, {29'd0, e[2:0]});
  endtask

  task automatic commit(input string tag, input logic [W-1:0] rec, input logic e_done,
      input logic e_fail, input logic [31:0] e_cnt, input logic [31:0] e_inum,
      input logic [2:0] e_code);
    @(negedge clk);
    tr.cm_valid = 1'b1;
    tr.cm_rec   = rec;
    exp_q.push_back({e_done, e_fail, e_cnt, e_inum, e_code});
    @(posedge clk);
    #1;
    tr.cm_valid = 1'b0;
    pop_and_check(tag);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] r0, r1, r2, rb, bad, r9;
  logic [W-1:0] fill [8];
  logic [15:0]  junk;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    tr.exp_valid = 1'b0;
    tr.cm_valid  = 1'b0;
    tr.exp_rec   = '0;
    tr.cm_rec    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset.ready", {31'd0, tr.exp_ready}, 32'd0);
    check("reset.done",  {31'd0, done}, 32'd0);
    check("reset.fail",  {31'd0, fail}, 32'd0);
    check("reset.count", inst_count, 32'd0);
    check("reset.inum",  err_inum, 32'd0);
    check("reset.code",  {29'd0, err_code}, {29'd0, ERR_NONE});
    rst = 1'b1;
    #1;
    check("run.ready", {31'd0, tr.exp_ready}, 32'd1);

    // Matching stream ending in halt, then one extra commit
    r0 = mk_rec(16'h0000, 1'b1, 3'd1, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    r1 = mk_rec(16'h0002, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h0005, 1'b0);
    r2 = mk_rec(16'h0004, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    load(r0); load(r1); load(r2);
    commit("match.c0", r0, 1'b0, 1'b0, 32'd1, 32'd0, ERR_NONE);
    commit("match.c1", r1, 1'b0, 1'b0, 32'd2, 32'd0, ERR_NONE);
    commit("match.halt", r2, 1'b1, 1'b0, 32'd3, 32'd0, ERR_NONE);
    check("done.ready", {31'd0, tr.exp_ready}, 32'd0);
    commit("extra", r0, 1'b1, 1'b1, 32'd3, 32'd3, ERR_EXTRA);

    // Register data mismatch on the second commit; later commits ignored
    apply_reset();
    rb = mk_rec(16'h0002, 1'b1, 3'd2, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    load(r0); load(rb);
    commit("regerr.c0", r0, 1'b0, 1'b0, 32'd1, 32'd0, ERR_NONE);
    bad = rb;
    bad[WDATA_LSB +: 16] = 16'h0006;
    commit("regerr.c1", bad, 1'b0, 1'b1, 32'd1, 32'd1, ERR_REG);
    commit("regerr.ignored", rb, 1'b0, 1'b1, 32'd1, 32'd1, ERR_REG);

    // Don't-care fields may differ without failing
    apply_reset();
    r0 = mk_rec(16'h0100, 1'b0, 3'd4, 16'h1111, 1'b0, 1'b0, 16'h2222, 16'h3333, 1'b0);
    r1 = mk_rec(16'h0102, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h7777, 1'b0);
    r2 = mk_rec(16'h0104, 1'b1, 3'd5, 16'h00AA, 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0);
    load(r0); load(r1); load(r2);
    bad = r0;
    junk = 16'($urandom_range(1, 65535));
    bad[WDATA_LSB +: 16] = bad[WDATA_LSB +: 16] ^ junk;
    bad[WREG_LSB +: 3]   = bad[WREG_LSB +: 3] ^ 3'd3;
    bad[ADDR_LSB +: 16]  = bad[ADDR_LSB +: 16] ^ junk;
    bad[MDATA_LSB +: 16] = bad[MDATA_LSB +: 16] ^ junk;
    bad[W-1 -: 16]       = junk;
    commit("dc.noreg_nomem", bad, 1'b0, 1'b0, 32'd1, 32'd0, ERR_NONE);
    bad = r1;
    bad[MDATA_LSB +: 16] = bad[MDATA_LSB +: 16] ^ 16'($urandom_range(1, 65535));
    commit("dc.memread_mdata", bad, 1'b0, 1'b0, 32'd2, 32'd0, ERR_NONE);
    bad = r2;
    bad[ADDR_LSB +: 16]  = bad[ADDR_LSB +: 16] ^ 16'($urandom_range(1, 65535));
    commit("dc.reg_addr", bad, 1'b0, 1'b0, 32'd3, 32'd0, ERR_NONE);

    // One corruption per error class on a full-featured record
    rb = mk_rec(16'h0200, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b1, 16'h0040, 16'h0099, 1'b0);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] e_code;
      apply_reset();
      load(rb);
      bad = rb;
      case (k)
        0: begin bad[PC_LSB +: 16]    = 16'h0202; e_code = ERR_PC;   end
        1: begin bad[WREG_LSB +: 3]   = 3'd6;     e_code = ERR_REG;  end
        2: begin bad[ADDR_LSB +: 16]  = 16'h0044; e_code = ERR_MEM;  end
        3: begin bad[MDATA_LSB +: 16] = 16'h0098; e_code = ERR_MEM;  end
        4: begin bad[MEMREAD_BIT]     = 1'b1;     e_code = ERR_MEM;  end
        default: begin bad[HALT_BIT]  = 1'b1;     e_code = ERR_HALT; end
      endcase
      commit($sformatf("errclass.k%0d", k), bad, 1'b0, 1'b1, 32'd0, 32'd0, e_code);
    end

    // Asynchronous reset mid-stream, then underflow proves nothing survived
    apply_reset();
    load(r0); load(r1);
    commit("async.c0", r0, 1'b0, 1'b0, 32'd1, 32'd0, ERR_NONE);
    #3;
    rst = 1'b0;
    #1;
    check("async.count", inst_count, 32'd0);
    check("async.ready", {31'd0, tr.exp_ready}, 32'd0);
    check("async.state", {30'd0, dbg_state}, {30'd0, ST_RUN});
    @(negedge clk);
    rst = 1'b1;
    commit("underflow", r1, 1'b0, 1'b1, 32'd0, 32'd0, ERR_UNDERFLOW);

    // Fill to DEPTH, reject the 9th, push+pop while full only pops
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      fill[i] = mk_rec(16'(i * 2), 1'b1, 3'($urandom_range(0, 7)),
                       16'($urandom_range(0, 65535)), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      load(fill[i]);
    end
    r9 = mk_rec(16'h0010, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    check("full.ready", {31'd0, tr.exp_ready}, 32'd0);
    tr.exp_valid = 1'b1;
    tr.exp_rec   = r9;
    tr.cm_valid  = 1'b1;
    tr.cm_rec    = fill[0];
    exp_q.push_back({1'b0, 1'b0, 32'd1, 32'd0, ERR_NONE});
    @(posedge clk);
    #1;
    tr.exp_valid = 1'b0;
    tr.cm_valid  = 1'b0;
    pop_and_check("full.push_pop");
    for (int i = 1; i < 8; i++)
      commit($sformatf("full.c%0d", i), fill[i], 1'b0, 1'b0, 32'(i + 1), 32'd0, ERR_NONE);
    commit("full.ninth_dropped", r9, 1'b0, 1'b1, 32'd8, 32'd8, ERR_UNDERFLOW);

    // Idle watchdog
    apply_reset();
    load(r0);
    commit("idle.c0", r0, 1'b0, 1'b0, 32'd1, 32'd0, ERR_NONE);
    repeat (15) @(posedge clk);
    #1;
    check("idle.before_limit", {31'd0, fail}, 32'd0);
    @(posedge clk);
    #1;
`ifdef COMMIT_TRACE_TIMEOUT_EN
    check("idle.fail", {31'd0, fail}, 32'd1);
    check("idle.code", {29'd0, err_code}, {29'd0, ERR_TIMEOUT});
    check("idle.inum", err_inum, 32'd1);
`else
    check("idle.fail", {31'd0, fail}, 32'd0);
    check("idle.code", {29'd0, err_code}, {29'd0, ERR_NONE});
    check("idle.done", {31'd0, done}, 32'd0);
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
